bin_to_bcd_seq: RTL

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Produces the four BCD digits that feed the unit, tens, hundreds and thousands 7-segment display stages.
- Sits between the binary datapath and the display decoders, so the datapath never has to produce BCD itself.
- Start/ready/done handshake; digit outputs are registered and held between conversions.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_add3.sv | 20 ++
 rtl/bin_to_bcd_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DIGITS   : number of BCD digits produced (units..thousands)
//   MAX_BCD  : largest value representable in DIGITS decimal digits
//   BCD_NINE : digit value used when the result saturates
//   state_t  : converter FSM states
package bcd_pkg;

    localparam int          DIGITS   = 4;
    localparam int unsigned MAX_BCD  = 32'd9999;
    localparam logic [3:0]  BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
//   value    in  4  scratch nibble before correction
//   adjusted out 4  corrected nibble
module bcd_add3 (
    input  logic [3:0] value,
    output logic [3:0] adjusted
);

    // Conditional +3 correction of one BCD nibble.
    always_comb begin
        adjusted = value;
        if (value >= 4'd5) begin
            adjusted = value + 4'd3;
        end else begin
            adjusted = value;
        end
    end

endmodule : bcd_add3

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds the four 7-segment display stages with registered, held digits.
//   clk       in  1      system clock, rising edge
//   rst       in  1      synchronous reset, active-high
//   start     in  1      conversion request, sampled only while ready=1
//   bin_in    in  BIN_W  binary value, captured on the accepted start cycle
//   ready     out 1      high only in IDLE
//   done      out 1      one-cycle pulse, digits valid/updated this cycle
//   overflow  out 1      captured value exceeded 9999 (digits saturate to 9999)
//   unidades  out 4      units digit
//   decenas   out 4      tens digit
//   centenas  out 4      hundreds digit
//   miles     out 4      thousands digit
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             ready,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       unidades,
    output logic [3:0]       decenas,
    output logic [3:0]       centenas,
    output logic [3:0]       miles
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = 4 * DIGITS;

    state_t             state_r;
    state_t             next_state_s;
    logic [BIN_W-1:0]   shift_r;
    logic [BIN_W-1:0]   shift_nx_s;
    logic [SCR_W-1:0]   scratch_r;
    logic [SCR_W-1:0]   adj_s;
    logic [SCR_W-1:0]   scratch_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_pend_r;
    logic               ovf_pend_nx_s;
    logic               in_ovf_s;
    logic               last_shift_s;

    // One add-3 corrector per scratch nibble.
    genvar g;
    for (g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .value    (scratch_r[4*g +: 4]),
            .adjusted (adj_s[4*g +: 4])
        );
    end

    // Corrected scratch and shift register move left together by one bit;
    // the bit leaving the top of the scratch is discarded.
    assign scratch_nx_s = {adj_s[SCR_W-2:0], shift_r[BIN_W-1]};
    assign shift_nx_s   = {shift_r[BIN_W-2:0], 1'b0};

    // A set top bit after correction means the result already exceeds 9999,
    // which only happens when the capture-time overflow flag is set anyway;
    // folding it in keeps that discarded bit meaningful.
    assign ovf_pend_nx_s = ovf_pend_r | adj_s[SCR_W-1];

    assign in_ovf_s     = (32'(bin_in) > MAX_BCD);
    assign last_shift_s = (cnt_r == CNT_W'(1));

    // Next-state logic of the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_shift_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            scratch_r  <= '0;
            cnt_r      <= '0;
            ovf_pend_r <= 1'b0;
            ready      <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            unidades   <= 4'd0;
            decenas    <= 4'd0;
            centenas   <= 4'd0;
            miles      <= 4'd0;
        end else begin
            state_r <= next_state_s;
            // ready/done decode the state being entered so they line up with it.
            ready   <= (next_state_s == IDLE);
            done    <= (next_state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shift_r    <= bin_in;
                        scratch_r  <= '0;
                        cnt_r      <= CNT_W'(BIN_W);
                        ovf_pend_r <= in_ovf_s;
                    end else begin
                        shift_r    <= shift_r;
                        scratch_r  <= scratch_r;
                        cnt_r      <= cnt_r;
                        ovf_pend_r <= ovf_pend_r;
                    end
                end
                SHIFT: begin
                    shift_r    <= shift_nx_s;
                    scratch_r  <= scratch_nx_s;
                    cnt_r      <= cnt_r - CNT_W'(1);
                    ovf_pend_r <= ovf_pend_nx_s;
                    // Digits load on the edge entering DONE so they are
                    // valid during the done pulse.
                    if (last_shift_s) begin
                        if (ovf_pend_nx_s) begin
                            overflow <= 1'b1;
                            unidades <= BCD_NINE;
                            decenas  <= BCD_NINE;
                            centenas <= BCD_NINE;
                            miles    <= BCD_NINE;
                        end else begin
                            overflow <= 1'b0;
                            unidades <= scratch_nx_s[3:0];
                            decenas  <= scratch_nx_s[7:4];
                            centenas <= scratch_nx_s[11:8];
                            miles    <= scratch_nx_s[15:12];
                        end
                    end else begin
                        overflow <= overflow;
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

endmodule : bin_to_bcd_seq
